// File: rtl/nic_pkg.sv
// Shared NIC port constants, packet width and controller state encoding.
package nic_pkg;
  localparam int PKT_W = 64;

  localparam logic [1:0] NIC_IN_DATA  = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_DATA = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  // Arbitration pointer values: which direction was served last.
  localparam logic SIDE_RX = 1'b0;
  localparam logic SIDE_TX = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_IST,
    ST_CHK_IST,
    ST_RD_DAT,
    ST_CAP_DAT,
    ST_RD_OST,
    ST_CHK_OST,
    ST_WR_DAT,
    ST_GAP
  } state_t;
endpackage

// File: rtl/nic_xfer_ctrl_if.sv
// PE-side FIFO handshake plus NIC register port of the transfer controller.
interface nic_xfer_ctrl_if;
  import nic_pkg::*;

  logic             tx_wr;
  logic [PKT_W-1:0] tx_data;
  logic             tx_full;
  logic             rx_rd;
  logic [PKT_W-1:0] rx_data;
  logic             rx_empty;
  logic             nic_en;
  logic             nic_wr_en;
  logic [1:0]       nic_addr;
  logic [PKT_W-1:0] nic_wdata;
  logic [PKT_W-1:0] nic_rdata;
  logic [15:0]      tx_cnt;
  logic [15:0]      rx_cnt;

  modport slave (
    input  tx_wr, tx_data, rx_rd, nic_rdata,
    output tx_full, rx_data, rx_empty, nic_en, nic_wr_en, nic_addr, nic_wdata,
           tx_cnt, rx_cnt
  );

  modport master (
    output tx_wr, tx_data, rx_rd, nic_rdata,
    input  tx_full, rx_data, rx_empty, nic_en, nic_wr_en, nic_addr, nic_wdata,
           tx_cnt, rx_cnt
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; head reads as zero while empty, storage is not reset.
module sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  // Fullness is judged before the pop, so a push to a full FIFO is dropped.
  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/nic_xfer_ctrl.sv
// Round-robin NIC poller moving one packet per service between PE FIFOs and the NIC port.
module nic_xfer_ctrl
  import nic_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int POLL_GAP = 3
) (
  input logic            clk,
  input logic            reset,
  nic_xfer_ctrl_if.slave bus
);
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((POLL_GAP > 1) ? POLL_GAP - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic             w_last_nxt;
  logic [GAP_W-1:0] r_gap;
  logic             w_gap_load;
  logic [15:0]      r_tx_cnt;
  logic [15:0]      r_rx_cnt;
  logic             w_tx_pop;
  logic             w_rx_push;
  logic             w_tx_empty;
  logic             w_rx_full;
  logic             w_rx_elig;
  logic             w_tx_elig;
  logic [PKT_W-1:0] w_tx_head;

  sync_fifo #(.DATA_W(PKT_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.tx_wr),
    .i_data  (bus.tx_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (bus.tx_full),
    .o_empty (w_tx_empty)
  );

  sync_fifo #(.DATA_W(PKT_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rx_push),
    .i_data  (bus.nic_rdata),
    .i_pop   (bus.rx_rd),
    .o_data  (bus.rx_data),
    .o_full  (w_rx_full),
    .o_empty (bus.rx_empty)
  );

  assign w_rx_elig  = !w_rx_full;
  assign w_tx_elig  = !w_tx_empty;
  assign bus.tx_cnt = r_tx_cnt;
  assign bus.rx_cnt = r_rx_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_last   <= SIDE_TX;
      r_gap    <= '0;
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_nxt;
      if (w_gap_load)                            r_gap <= GAP_LOAD;
      else if (r_state == ST_GAP && r_gap != '0) r_gap <= r_gap - 1'b1;
      if (w_tx_pop)  r_tx_cnt <= r_tx_cnt + 16'd1;
      if (w_rx_push) r_rx_cnt <= r_rx_cnt + 16'd1;
    end
  end

  // NIC read data is registered, so status/data are checked one state after the request.
  always_comb begin
    w_next     = r_state;
    w_last_nxt = r_last;
    w_gap_load = 1'b0;
    w_tx_pop   = 1'b0;
    w_rx_push  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_elig && (!w_tx_elig || r_last == SIDE_TX)) begin
          w_next     = ST_RD_IST;
          w_last_nxt = SIDE_RX;
        end else if (w_tx_elig) begin
          w_next     = ST_RD_OST;
          w_last_nxt = SIDE_TX;
        end
      end
      ST_RD_IST: w_next = ST_CHK_IST;
      ST_CHK_IST: begin
        if (bus.nic_rdata[0]) begin
          w_next = ST_RD_DAT;
        end else begin
          w_next     = ST_GAP;
          w_gap_load = 1'b1;
        end
      end
      ST_RD_DAT: w_next = ST_CAP_DAT;
      ST_CAP_DAT: begin
        w_rx_push = 1'b1;
        w_next    = ST_IDLE;
      end
      ST_RD_OST: w_next = ST_CHK_OST;
      ST_CHK_OST: begin
        if (!bus.nic_rdata[0]) begin
          w_next = ST_WR_DAT;
        end else begin
          w_next     = ST_GAP;
          w_gap_load = 1'b1;
        end
      end
      ST_WR_DAT: begin
        w_tx_pop = 1'b1;
        w_next   = ST_IDLE;
      end
      ST_GAP: begin
        if (r_gap == '0) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.nic_en    = 1'b0;
    bus.nic_wr_en = 1'b0;
    bus.nic_addr  = NIC_IN_DATA;
    bus.nic_wdata = '0;
    case (r_state)
      ST_RD_IST: begin
        bus.nic_en   = 1'b1;
        bus.nic_addr = NIC_IN_STAT;
      end
      ST_RD_DAT: begin
        bus.nic_en   = 1'b1;
        bus.nic_addr = NIC_IN_DATA;
      end
      ST_RD_OST: begin
        bus.nic_en   = 1'b1;
        bus.nic_addr = NIC_OUT_STAT;
      end
      ST_WR_DAT: begin
        bus.nic_en    = 1'b1;
        bus.nic_wr_en = 1'b1;
        bus.nic_addr  = NIC_OUT_DATA;
        bus.nic_wdata = w_tx_head;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_nic_xfer_ctrl.sv
// Bench for nic_xfer_ctrl: NIC register model, directed scenarios and a randomized scoreboard run.
module tb_nic_xfer_ctrl;
  import nic_pkg::*;

  localparam int DEPTH    = 4;
  localparam int POLL_GAP = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  nic_xfer_ctrl_if bus ();

  nic_xfer_ctrl #(.DEPTH(DEPTH), .POLL_GAP(POLL_GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [63:0] in_q[$];
  logic [63:0] delivered[$];
  logic [63:0] wr_log[$];
  bit          svc[$];
  bit          out_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // NIC model: input buffer queue, output-busy flag, registered read data.
  always @(posedge clk) begin
    logic [63:0] d;
    if (!reset) begin
      bus.nic_rdata <= '0;
    end else if (bus.nic_en && !bus.nic_wr_en) begin
      case (bus.nic_addr)
        2'b00: begin
          d = '0;
          if (in_q.size() != 0) d = in_q.pop_front();
          delivered.push_back(d);
          bus.nic_rdata <= d;
        end
        2'b01:   bus.nic_rdata <= {63'd0, in_q.size() != 0};
        2'b11:   bus.nic_rdata <= {63'd0, out_busy};
        default: bus.nic_rdata <= '0;
      endcase
    end
  end

  // Port monitor: service order (0 = RX data read, 1 = TX data write) and written packets.
  always @(negedge clk) begin
    if (bus.nic_en && bus.nic_wr_en) begin
      wr_log.push_back(bus.nic_wdata);
      svc.push_back(1'b1);
    end else if (bus.nic_en && bus.nic_addr == 2'b00) begin
      svc.push_back(1'b0);
    end
  end

  task automatic do_reset();
    bus.tx_wr = 1'b0;
    bus.rx_rd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    in_q.delete();
    delivered.delete();
    wr_log.delete();
    svc.delete();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    int r, first, prev, n_ist, bad, other;
    bus.tx_wr = 1'b0; bus.tx_data = '0; bus.rx_rd = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.tx_full !== 1'b0) begin n_err++; $display("FAIL reset_tx_full: got %0b want 0", bus.tx_full); end
    n_cmp++; if (bus.rx_empty !== 1'b1) begin n_err++; $display("FAIL reset_rx_empty: got %0b want 1", bus.rx_empty); end
    n_cmp++; if (bus.rx_data !== 64'd0) begin n_err++; $display("FAIL reset_rx_data: got %h want 0", bus.rx_data); end
    n_cmp++; if ({bus.nic_en, bus.nic_wr_en, bus.nic_addr} !== 4'b0000) begin n_err++;
      $display("FAIL reset_port: got en/wr/addr %b want 0000", {bus.nic_en, bus.nic_wr_en, bus.nic_addr}); end
    n_cmp++; if (bus.nic_wdata !== 64'd0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", bus.nic_wdata); end
    n_cmp++; if ({bus.tx_cnt, bus.rx_cnt} !== 32'd0) begin n_err++;
      $display("FAIL reset_counts: got tx %0d rx %0d want 0/0", bus.tx_cnt, bus.rx_cnt); end
    in_q.delete(); delivered.delete(); wr_log.delete(); svc.delete();
    reset = 1'b1;
    r = cyc; first = -1; prev = 0; n_ist = 0; bad = 0; other = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus.nic_en && !bus.nic_wr_en && bus.nic_addr == 2'b01) begin
        if (first < 0) first = cyc;
        else if (cyc - prev != 6) bad++;
        prev = cyc;
        n_ist++;
      end else if (bus.nic_en) begin
        other++;
      end
    end
    n_cmp++; if (first != r + 1) begin n_err++; $display("FAIL idle_first_poll: got cycle %0d want %0d", first, r + 1); end
    n_cmp++; if (n_ist != 4 || bad != 0) begin n_err++;
      $display("FAIL idle_poll_period: got %0d polls, %0d bad gaps want 4 polls 6 apart", n_ist, bad); end
    n_cmp++; if (other != 0) begin n_err++; $display("FAIL idle_other_access: got %0d want 0", other); end
  endtask

  task automatic test_rx_single();
    bit found = 0;
    in_q.push_back(64'hDEAD_BEEF_0000_0001);
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.nic_en && !bus.nic_wr_en && bus.nic_addr == 2'b00) found = 1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL rx_data_read: got none want addr 00 read"); end
    n_cmp++; if (bus.rx_empty !== 1'b1) begin n_err++; $display("FAIL rx_empty_rd_dat: got %0b want 1", bus.rx_empty); end
    @(negedge clk);
    n_cmp++; if (bus.rx_empty !== 1'b1 || bus.nic_en !== 1'b0) begin n_err++;
      $display("FAIL rx_cap_dat: got empty %0b en %0b want 1/0", bus.rx_empty, bus.nic_en); end
    @(negedge clk);
    n_cmp++; if (bus.rx_empty !== 1'b0) begin n_err++; $display("FAIL rx_empty_after_cap: got %0b want 0", bus.rx_empty); end
    n_cmp++; if (bus.rx_data !== 64'hDEAD_BEEF_0000_0001) begin n_err++;
      $display("FAIL rx_data: got %h want deadbeef00000001", bus.rx_data); end
    n_cmp++; if (bus.rx_cnt !== 16'd1) begin n_err++; $display("FAIL rx_cnt_one: got %0d want 1", bus.rx_cnt); end
    bus.rx_rd = 1'b1;
    @(negedge clk);
    bus.rx_rd = 1'b0;
    n_cmp++; if (bus.rx_empty !== 1'b1) begin n_err++; $display("FAIL rx_pop_empty: got %0b want 1", bus.rx_empty); end
  endtask

  task automatic test_tx_single();
    bit found = 0;
    out_busy = 1'b0;
    @(negedge clk);
    bus.tx_wr = 1'b1; bus.tx_data = 64'h8000_0000_0000_00AA;
    @(negedge clk);
    bus.tx_wr = 1'b0;
    if (bus.nic_en && bus.nic_wr_en) found = 1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.nic_en && bus.nic_wr_en) found = 1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL tx_write_seen: got none want a write"); end
    n_cmp++; if (bus.nic_addr !== 2'b10 || bus.nic_wdata !== 64'h8000_0000_0000_00AA) begin n_err++;
      $display("FAIL tx_write: got addr %b data %h want 10 / 80000000000000aa", bus.nic_addr, bus.nic_wdata); end
    n_cmp++; if (bus.tx_cnt !== 16'd0) begin n_err++; $display("FAIL tx_cnt_during_wr: got %0d want 0", bus.tx_cnt); end
    @(negedge clk);
    n_cmp++; if (bus.tx_cnt !== 16'd1) begin n_err++; $display("FAIL tx_cnt_one: got %0d want 1", bus.tx_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] tx_exp[$], rx_exp[$];
    bit done = 0;
    do_reset();
    out_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_exp.push_back({$urandom, $urandom});
      in_q.push_back(rx_exp[i]);
      tx_exp.push_back({$urandom, $urandom});
    end
    for (int i = 0; i < 4; i++) begin
      bus.tx_wr = 1'b1; bus.tx_data = tx_exp[i];
      @(negedge clk);
    end
    bus.tx_wr = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.tx_cnt == 16'd4 && bus.rx_cnt == 16'd4) done = 1;
    end
    repeat (20) @(negedge clk);
    n_cmp++; if (bus.tx_cnt !== 16'd4 || bus.rx_cnt !== 16'd4) begin n_err++;
      $display("FAIL b2b_counts: got tx %0d rx %0d want 4/4", bus.tx_cnt, bus.rx_cnt); end
    n_cmp++; if (svc.size() != 8) begin n_err++; $display("FAIL b2b_services: got %0d want 8", svc.size()); end
    for (int i = 0; i < 8 && i < svc.size(); i++) begin
      n_cmp++; if (svc[i] !== i[0]) begin n_err++;
        $display("FAIL b2b_order[%0d]: got %s want %s", i, svc[i] ? "TX" : "RX", i[0] ? "TX" : "RX"); end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (i >= wr_log.size() || wr_log[i] !== tx_exp[i]) begin n_err++;
        $display("FAIL b2b_tx_data[%0d]: got %h want %h", i, (i < wr_log.size()) ? wr_log[i] : 64'hx, tx_exp[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.rx_empty !== 1'b0 || bus.rx_data !== rx_exp[i]) begin n_err++;
        $display("FAIL b2b_rx_data[%0d]: got %h want %h", i, bus.rx_data, rx_exp[i]); end
      bus.rx_rd = 1'b1;
      @(negedge clk);
      bus.rx_rd = 1'b0;
    end
  endtask

  task automatic test_tx_full();
    logic [63:0] tx_exp[$];
    bit done = 0;
    do_reset();
    out_busy = 1'b1;
    for (int i = 0; i < 5; i++) tx_exp.push_back({$urandom, $urandom});
    for (int i = 0; i < 4; i++) begin
      bus.tx_wr = 1'b1; bus.tx_data = tx_exp[i];
      @(negedge clk);
    end
    bus.tx_wr = 1'b0;
    n_cmp++; if (bus.tx_full !== 1'b1) begin n_err++; $display("FAIL txf_full: got %0b want 1", bus.tx_full); end
    bus.tx_wr = 1'b1; bus.tx_data = tx_exp[4];
    @(negedge clk);
    bus.tx_wr = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++; if (bus.tx_full !== 1'b1 || wr_log.size() != 0 || bus.tx_cnt !== 16'd0) begin n_err++;
      $display("FAIL txf_blocked: got full %0b writes %0d cnt %0d want 1/0/0", bus.tx_full, wr_log.size(), bus.tx_cnt); end
    out_busy = 1'b0;
    for (int i = 0; i < 150 && !done; i++) begin
      @(negedge clk);
      if (bus.tx_cnt == 16'd4) done = 1;
    end
    repeat (30) @(negedge clk);
    n_cmp++; if (wr_log.size() != 4 || bus.tx_cnt !== 16'd4 || bus.tx_full !== 1'b0) begin n_err++;
      $display("FAIL txf_drain: got writes %0d cnt %0d full %0b want 4/4/0", wr_log.size(), bus.tx_cnt, bus.tx_full); end
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      n_cmp++; if (wr_log[i] !== tx_exp[i]) begin n_err++;
        $display("FAIL txf_order[%0d]: got %h want %h", i, wr_log[i], tx_exp[i]); end
    end
  endtask

  task automatic test_reset_in_cap();
    bit found = 0;
    do_reset();
    in_q.push_back({$urandom, $urandom});
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.nic_en && !bus.nic_wr_en && bus.nic_addr == 2'b00) found = 1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL rcap_rd_dat: got none want addr 00 read"); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.rx_empty !== 1'b1 || bus.rx_cnt !== 16'd0 || bus.tx_full !== 1'b0) begin n_err++;
      $display("FAIL rcap_flush: got rx_empty %0b rx_cnt %0d tx_full %0b want 1/0/0", bus.rx_empty, bus.rx_cnt, bus.tx_full); end
    n_cmp++; if (bus.nic_en !== 1'b0) begin n_err++; $display("FAIL rcap_no_access: got en %0b want 0", bus.nic_en); end
    in_q.delete(); delivered.delete(); wr_log.delete(); svc.delete();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (!(bus.nic_en && !bus.nic_wr_en && bus.nic_addr == 2'b01)) begin n_err++;
      $display("FAIL rcap_restart: got en %0b addr %b want 1/01", bus.nic_en, bus.nic_addr); end
  endtask

  task automatic test_random();
    logic [63:0] m_tx_q[$], m_rx_q[$];
    int  m_tx_n = 0, m_rx_n = 0;
    bit  cap_pend = 0, stim, w, rdd, push_ok;
    do_reset();
    for (int c = 0; c < 1700; c++) begin
      stim = (c < 1500);
      @(negedge clk);
      n_cmp++; if (bus.tx_full !== (m_tx_q.size() == DEPTH)) begin n_err++;
        $display("FAIL rnd_tx_full@%0d: got %0b want %0b", c, bus.tx_full, m_tx_q.size() == DEPTH); end
      n_cmp++; if (bus.rx_empty !== (m_rx_q.size() == 0)) begin n_err++;
        $display("FAIL rnd_rx_empty@%0d: got %0b want %0b", c, bus.rx_empty, m_rx_q.size() == 0); end
      if (m_rx_q.size() != 0) begin
        n_cmp++; if (bus.rx_data !== m_rx_q[0]) begin n_err++;
          $display("FAIL rnd_rx_data@%0d: got %h want %h", c, bus.rx_data, m_rx_q[0]); end
      end
      w   = bus.nic_en && bus.nic_wr_en;
      rdd = bus.nic_en && !bus.nic_wr_en && bus.nic_addr == 2'b00;
      if (w) begin
        n_cmp++; if (m_tx_q.size() == 0 || bus.nic_wdata !== m_tx_q[0] || bus.nic_addr !== 2'b10) begin n_err++;
          $display("FAIL rnd_tx_write@%0d: got addr %b data %h want 10 / %h", c, bus.nic_addr, bus.nic_wdata,
                   (m_tx_q.size() != 0) ? m_tx_q[0] : 64'hx); end
      end
      bus.tx_wr   = stim && ($urandom_range(0, 3) == 0);
      bus.tx_data = {$urandom, $urandom};
      bus.rx_rd   = ($urandom_range(0, 2) == 0);
      if (stim && $urandom_range(0, 9) == 0 && in_q.size() < 2) in_q.push_back({$urandom, $urandom});
      out_busy    = stim && ($urandom_range(0, 3) == 0);
      push_ok = bus.tx_wr && (m_tx_q.size() < DEPTH);
      if (w && m_tx_q.size() != 0) begin void'(m_tx_q.pop_front()); m_tx_n++; end
      if (push_ok) m_tx_q.push_back(bus.tx_data);
      if (bus.rx_rd && m_rx_q.size() != 0) void'(m_rx_q.pop_front());
      if (cap_pend) begin
        if (delivered.size() != 0) m_rx_q.push_back(delivered.pop_front());
        m_rx_n++;
      end
      cap_pend = rdd;
    end
    @(negedge clk);
    bus.tx_wr = 1'b0; bus.rx_rd = 1'b0;
    n_cmp++; if (bus.tx_cnt !== 16'(m_tx_n) || bus.rx_cnt !== 16'(m_rx_n)) begin n_err++;
      $display("FAIL rnd_counts: got tx %0d rx %0d want %0d/%0d", bus.tx_cnt, bus.rx_cnt, m_tx_n, m_rx_n); end
    n_cmp++; if (m_tx_q.size() != 0 || m_tx_n == 0 || m_rx_n == 0) begin n_err++;
      $display("FAIL rnd_progress: got tx left %0d, tx %0d rx %0d want 0 left and traffic both ways",
               m_tx_q.size(), m_tx_n, m_rx_n); end
  endtask

  initial begin
    bus.tx_wr   = 1'b0;
    bus.tx_data = '0;
    bus.rx_rd   = 1'b0;
    test_reset();
    test_rx_single();
    test_tx_single();
    test_back_to_back();
    test_tx_full();
    test_reset_in_cap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/nic_xfer_ctrl.md
# nic_xfer_ctrl

PE-side transfer controller that sequences the NIC register port so the processing element never polls it directly. It owns a transmit FIFO (PE → NIC output buffer) and a receive FIFO (NIC input buffer → PE). It polls NIC status with round-robin fairness between the two directions and moves one 64-bit packet per service. It sits between the PE datapath and the `nic` block's `nicEn/nicWrEN/addr/d_in/d_out` port.

## Interface
- `DEPTH`, default 4: entries per FIFO; a power of two, ≥ 2.
- `POLL_GAP`, default 3: idle cycles inserted after a status check that finds nothing to do, ≥ 0.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets the block.
- `tx_wr` in 1: push `tx_data` into the TX FIFO.
- `tx_data` in 64: packet to send.
- `tx_full` out 1: TX FIFO full.
- `rx_rd` in 1: pop the RX FIFO head.
- `rx_data` out 64: RX FIFO head; valid only while `rx_empty==0`.
- `rx_empty` out 1: RX FIFO empty.
- `nic_en` out 1: drives NIC `nicEn`.
- `nic_wr_en` out 1: drives NIC `nicWrEN`.
- `nic_addr` out 2: drives NIC `addr`.
- `nic_wdata` out 64: drives NIC `d_in`.
- `nic_rdata` in 64: from NIC `d_out`; registered in the NIC, so valid one cycle after a read request.
- `tx_cnt` out 16: packets written to the NIC; wraps at 2^16.
- `rx_cnt` out 16: packets read from the NIC; wraps at 2^16.

## Operation
- NIC addresses: 00 = input data read, 01 = input status read, 10 = output data write, 11 = output status read. The status bit is `nic_rdata[0]`.
- FSM states:
  - IDLE
  - RD_IST: `nic_en=1`, `wr=0`, `addr=01`.
  - CHK_IST: port idle.
  - RD_DAT: `nic_en=1`, `wr=0`, `addr=00`.
  - CAP_DAT: port idle.
  - RD_OST: `nic_en=1`, `wr=0`, `addr=11`.
  - CHK_OST: port idle.
  - WR_DAT: `nic_en=1`, `wr=1`, `addr=10`, `nic_wdata` = TX head.
  - GAP: port idle.
- Eligibility:
  - RX side is eligible when the RX FIFO is not full.
  - TX side is eligible when the TX FIFO is not empty.
- IDLE:
  - If both sides are eligible, pick the side opposite the 1-bit `last` pointer.
  - If one side is eligible, pick it.
  - If neither is eligible, stay in IDLE.
  - `last` updates to the side chosen.
- RX path:
  - RD_IST → CHK_IST.
  - In CHK_IST: if `nic_rdata[0]==1`, go to RD_DAT; otherwise go to GAP.
  - RD_DAT → CAP_DAT.
  - CAP_DAT pushes `nic_rdata` into the RX FIFO, increments `rx_cnt`, then goes to IDLE.
- TX path:
  - RD_OST → CHK_OST.
  - In CHK_OST: if `nic_rdata[0]==0` (output buffer empty), go to WR_DAT; otherwise go to GAP.
  - WR_DAT pops the TX head, increments `tx_cnt`, then goes to IDLE.
- GAP:
  - Stays for `POLL_GAP` cycles, counted down by a down-counter, then goes to IDLE.
  - With `POLL_GAP=0`, GAP lasts 1 cycle.
- The RX FIFO cannot fill between IDLE and CAP_DAT: only the PE pops during that window. No overflow check is needed at CAP_DAT.
- `nic_en/nic_wr_en/nic_addr/nic_wdata` are decoded from the registered state only, never from inputs. In non-driving states all four are 0.
- FIFOs:
  - `tx_wr` while `tx_full` is ignored.
  - `rx_rd` while `rx_empty` is ignored.
  - Simultaneous push and pop on the same FIFO are both performed when legal. A push to a full FIFO is still ignored even if a pop occurs the same cycle.

## Timing
- Reset values: state IDLE, `last=TX` (so RX wins the first tie), both FIFOs empty.
  - `tx_full=0`, `rx_empty=1`, `rx_data=0`.
  - `nic_en=0`, `nic_wr_en=0`, `nic_addr=00`, `nic_wdata=0`.
  - `tx_cnt=0`, `rx_cnt=0`.
- RX service: 5 cycles (IDLE, RD_IST, CHK_IST, RD_DAT, CAP_DAT). The packet is visible on `rx_data` in the cycle after CAP_DAT.
- TX service: 4 cycles (IDLE, RD_OST, CHK_OST, WR_DAT). `tx_full` deasserts the cycle after WR_DAT.
- Failed check: 3 + max(`POLL_GAP`,1) cycles back to IDLE.
- `tx_wr` to TX eligibility: 1 cycle, with the registered FIFO count.
- Reset mid-operation:
  - Any state returns to IDLE and both FIFOs flush.
  - A packet in flight during CAP_DAT is lost, because the NIC has already cleared its input status. This is accepted behaviour.

## Structure
- Shared package `nic_pkg`:
  - NIC address constants `NIC_IN_DATA`, `NIC_IN_STAT`, `NIC_OUT_DATA`, `NIC_OUT_STAT`.
  - Packet width constant 64.
  - The FSM state enum.
- Sub-module `sync_fifo` (parameters: width, depth), instantiated twice, for TX and RX.
- The FSM, arbitration pointer, gap counter and packet counters live in the top module.

## Test plan
1. Reset held low 2 cycles:
   - All outputs at reset values.
   - After release with no traffic, RX eligible: RD_IST issued (`nic_addr=01`), status 0 returned, GAP of 3 cycles, repeat every 6 cycles.
2. NIC model returns input status 1, then data 64'hDEAD_BEEF_0000_0001:
   - `rx_empty` falls after CAP_DAT, `rx_data`=64'hDEAD_BEEF_0000_0001, `rx_cnt=1`.
3. Push 64'h8000_0000_0000_00AA, NIC output status 0:
   - WR_DAT drives `nic_addr=10`, `nic_wr_en=1`, `nic_wdata`=64'h8000_0000_0000_00AA; `tx_cnt=1`.
4. Both sides pending continuously:
   - Services alternate RX, TX, RX, TX starting with RX.
   - 4 RX and 4 TX packets complete with counts 4/4.
5. Fill TX FIFO (4 pushes) with NIC output status stuck at 1:
   - `tx_full=1` and a 5th push is ignored.
   - After status drops to 0, 4 writes occur in push order.
6. Assert reset during CAP_DAT:
   - FIFOs empty, `rx_cnt=0`, state IDLE the next cycle, no NIC access in that cycle.
